// File: rtl/lea_pkg.sv
// Shared constants and types for the LEA round sequencing blocks.
// Key-mode codes, default round counts and the round FSM encoding.
package lea_pkg;

    localparam logic [1:0] KM_128 = 2'b00;
    localparam logic [1:0] KM_192 = 2'b01;
    localparam logic [1:0] KM_256 = 2'b10;
    localparam logic [1:0] KM_ILL = 2'b11;

    localparam int NR_128_DEF = 24;
    localparam int NR_192_DEF = 28;
    localparam int NR_256_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/lea_nr_decode.sv
// Key-mode to round-count decoder, shared with the key-schedule block.
// Purely combinational; flags the reserved mode code as illegal.
module lea_nr_decode
    import lea_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NR_128 = NR_128_DEF,
    parameter int NR_192 = NR_192_DEF,
    parameter int NR_256 = NR_256_DEF
) (
    input  logic [1:0]       key_mode,
    output logic [CNT_W-1:0] nr,
    output logic             ill
);

    // Map the mode code onto its round count
    always_comb begin
        nr  = '0;
        ill = 1'b0;
        unique case (key_mode)
            KM_128:  nr = CNT_W'(NR_128);
            KM_192:  nr = CNT_W'(NR_192);
            KM_256:  nr = CNT_W'(NR_256);
            default: ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/lea_round_counter.sv
// Start/busy/done round sequencer driving the LEA round core.
// Define LEA_BLK_CNT_EN to add the blk_cnt CTR-mode block counter.
module lea_round_counter
    import lea_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NR_128 = NR_128_DEF,
    parameter int NR_192 = NR_192_DEF,
    parameter int NR_256 = NR_256_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_mode,
    input  logic             dir,
    input  logic             stall,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             last_round,
    output logic             done,
    output logic             err
`ifdef LEA_BLK_CNT_EN
    ,
    output logic [CNT_W-1:0] blk_cnt
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if (CNT_W < 6) begin : g_cnt_w_chk
        $error("lea_round_counter: CNT_W must be >= 6");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [1:0]       dec_mode;
    logic [CNT_W-1:0] nr;
    logic             ill;
    logic [CNT_W-1:0] term;
    logic             at_term;

    // While idle decode the requested mode; afterwards the latched one
    assign dec_mode = (state_q == IDLE) ? key_mode : mode_q;

    lea_nr_decode #(
        .CNT_W  (CNT_W),
        .NR_128 (NR_128),
        .NR_192 (NR_192),
        .NR_256 (NR_256)
    ) u_nr_decode (
        .key_mode (dec_mode),
        .nr       (nr),
        .ill      (ill)
    );

    // Terminal index depends on the latched direction
    always_comb begin
        term    = dir_q ? '0 : (nr - ONE);
        at_term = (count_q == term);
    end

    // Next-state and registered-output logic of the round FSM
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (ill) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = key_mode;
                        dir_d   = dir;
                        count_d = dir ? (nr - ONE) : '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    if (at_term) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (dir_q) begin
                        count_d = count_q - ONE;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mode_q  <= KM_128;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign last_round = (state_q == RUN) && at_term;

`ifdef LEA_BLK_CNT_EN
    logic [CNT_W-1:0] blk_q, blk_d;

    // Block counter steps once per completed operation, wrapping freely
    always_comb begin
        blk_d = blk_q;
        if (state_q == DONE) begin
            blk_d = blk_q + ONE;
        end
    end

    // Block counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign blk_cnt = blk_q;
`endif

endmodule

// File: doc/lea_round_counter.md
Name: lea_round_counter

Overview:
- Parametrised round sequencer for the LEA datapath. It generalises the free-running 16-bit counter into a start/busy/done controlled round counter.
- Selects the round count from the key size: LEA-128 = 24, LEA-192 = 28, LEA-256 = 32 rounds.
- Counts up for encryption and down for decryption. Supports pipeline stall, and flags illegal modes.
- Drives round-key index and round-done timing for the LEA round core.

Parameters:
- CNT_W, 16, width of the count output. Must be >= 6 (elaboration-time check fails otherwise). Upper bits are always zero.
- NR_128, 24, rounds for key_mode 2'b00.
- NR_192, 28, rounds for key_mode 2'b01.
- NR_256, 32, rounds for key_mode 2'b10.

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- key_mode  in  2  00=128, 01=192, 10=256, 11=illegal; sampled with start
- dir  in  1  0 = encrypt (count up), 1 = decrypt (count down); sampled with start
- stall  in  1  hold count and state while in RUN
- count  out  CNT_W  current round index
- busy  out  1  high in RUN
- last_round  out  1  high in RUN while count equals the terminal index
- done  out  1  one-cycle pulse after the final round retires
- err  out  1  sticky illegal-mode flag

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, count=0, busy=0, last_round=0, done=0, err=0.
  - Reset has priority over all other inputs.
  - Reset mid-RUN aborts the operation; no done is produced.
- Nr is selected by the latched key_mode. The latched mode and dir stay fixed for the whole operation.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, key_mode!=11:
  - latch mode and dir;
  - count <= (dir ? Nr-1 : 0);
  - err <= 0;
  - state <= RUN.
- IDLE, start=1, key_mode==11: err <= 1; state stays IDLE; count unchanged.
- IDLE, start=0: hold all state. err holds its value.
- RUN, stall=1: count, state and last_round hold.
- RUN, stall=0, not at the terminal index: count advances by +1 (dir=0) or -1 (dir=1).
- RUN, stall=0, at the terminal index: count holds its final value; state <= DONE.
  - Terminal index is Nr-1 for dir=0 and 0 for dir=1.
- DONE: done=1 for exactly this cycle; busy=0; count holds the final value; state <= IDLE.
- start is ignored in RUN and DONE. There is no queueing. The earliest restart is start sampled in the first cycle back in IDLE.
- last_round is combinational from state and count. It is 0 outside RUN.
- Latency without stalls:
  - start sampled at edge 0;
  - busy=1 and count=first index after edge 0;
  - exactly Nr cycles with busy=1;
  - done high in the cycle after that.
  - Start to done = Nr+1 cycles. Each stalled cycle adds one.
- Count never wraps: a down-count never goes below 0, and an up-count never exceeds Nr-1.

Optional Feature:
- Macro: LEA_BLK_CNT_EN.
- Defined:
  - Adds output blk_cnt [CNT_W-1:0]. Reset value 0.
  - Increments by 1 in each DONE cycle.
  - Wraps modulo 2^CNT_W (all-ones -> 0).
  - Not affected by err or by aborted operations.
  - Used as the CTR-mode block counter.
- Undefined: no port and no register. All other behaviour is identical.

Decomposition:
- Package lea_pkg holds:
  - key-mode localparams KM_128, KM_192, KM_256, KM_ILL;
  - default round counts 24/28/32;
  - FSM state encoding IDLE/RUN/DONE as a 2-bit typedef.
- One sub-module, lea_nr_decode: combinational key_mode -> Nr and illegal flag. It is reused by the key-schedule block.
- The counter/FSM stays in lea_round_counter.

Test Plan:
- Encrypt 128: key_mode=00, dir=0, one-cycle start, no stall.
  - count 0..23 over 24 busy cycles;
  - last_round only at count=23;
  - done one cycle later, count held at 23;
  - done exactly 25 cycles after start.
- Decrypt 256 with stalls: key_mode=10, dir=1, stall=1 for 3 cycles at count=17.
  - count 31 down to 0;
  - count holds 17 for the 3 stall cycles;
  - done 36 cycles after start.
- Illegal mode: key_mode=11 with start → err=1, busy stays 0, count unchanged.
  - A following valid start with key_mode=01 clears err.
  - That run lasts 28 busy cycles (count 0..27).
- Reset mid-run: rst=1 at count=10 of a 192 encrypt run.
  - Next cycle count=0, busy=0, err=0;
  - no done pulse ever appears.
- Start while busy: start pulses at counts 5 and 20 of a 128 run are ignored (count sequence unchanged).
  - start held high through DONE launches a new run on the first IDLE cycle.
- LEA_BLK_CNT_EN defined: 3 back-to-back 128 encrypt runs → blk_cnt 0→1→2→3, each step on a done cycle.
  - With CNT_W=6 (blk_cnt=63 reached by forcing or by running), the next done wraps blk_cnt to 0.
